// File: rtl/enet_rx_cfg_sync_pkg.sv
// Shared constants for the ENET RX configuration block: register bit
// positions, the RCR reset value and the commit FSM state type.
package enet_pkg;

    // RCR bit positions
    localparam int unsigned RCR_NLC    = 30;
    localparam int unsigned RCR_CFEN   = 15;
    localparam int unsigned RCR_CRCFWD = 14;
    localparam int unsigned RCR_PAUFWD = 13;
    localparam int unsigned RCR_PADEN  = 12;
    localparam int unsigned RCR_FCE    = 5;
    localparam int unsigned RCR_BC_REJ = 4;
    localparam int unsigned RCR_PROM   = 3;
    localparam int unsigned RCR_DRT    = 1;

    // Bits of RCR that are backed by storage; all others read 0
    localparam logic [31:0] RCR_MASK =
        (32'd1 << RCR_NLC)    | (32'd1 << RCR_CFEN)   | (32'd1 << RCR_CRCFWD) |
        (32'd1 << RCR_PAUFWD) | (32'd1 << RCR_PADEN)  | (32'd1 << RCR_FCE)    |
        (32'd1 << RCR_BC_REJ) | (32'd1 << RCR_PROM)   | (32'd1 << RCR_DRT);

    localparam logic [31:0] RCR_RST = '0;

    // ECR bit positions
    localparam int unsigned ECR_MAX_FL_LSB = 16;
    localparam int unsigned ECR_MII_SEL    = 3;
    localparam int unsigned ECR_ETHER_EN   = 1;
    localparam int unsigned ECR_RESET      = 0;

    // SYNCED: active matches shadow; WAIT: a commit is outstanding
    typedef enum logic {
        CFG_SYNCED = 1'b0,
        CFG_WAIT   = 1'b1
    } cfg_state_e;

endpackage

// File: rtl/enet_cfg_field.sv
// One configuration field: a shadow register written by the host and an
// active register loaded from the shadow on commit. clr returns both to RST.
module enet_cfg_field #(
    parameter int unsigned   W   = 1,
    parameter logic [W-1:0]  RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         wen,
    input  logic [W-1:0] wdata,
    input  logic         commit,
    output logic [W-1:0] shadow,
    output logic [W-1:0] active
);

    logic [W-1:0] shadow_q, shadow_d;
    logic [W-1:0] active_q, active_d;

    // Next-state: clear wins, commit copies the pre-write shadow value
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (clr) begin
            shadow_d = RST;
            active_d = RST;
        end else begin
            if (commit) active_d = shadow_q;
            if (wen)    shadow_d = wdata;
        end
    end

    // Shadow/active storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= RST;
            active_q <= RST;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign shadow = shadow_q;
    assign active = active_q;

endmodule

// File: rtl/enet_rx_cfg_sync.sv
// Frame-safe RCR/ECR configuration: host writes land in shadow registers,
// and the whole active configuration is updated together between frames.
module enet_rx_cfg_sync
    import enet_pkg::*;
#(
    parameter int unsigned MAX_FL_W   = 14,
    parameter int unsigned MAX_FL_RST = 1518,
    parameter int unsigned MIN_FL     = 64
) (
    input  logic                rx_clk,
    input  logic                rst_n,
    input  logic                rcr_wen,
    input  logic                ecr_wen,
    input  logic [31:0]         reg_wdata,
    input  logic                rx_frame_busy,
    output logic [31:0]         rcr_rdata,
    output logic [31:0]         ecr_rdata,
    output logic                cfg_pending,
    output logic                ether_en,
    output logic                drt,
    output logic                mii_select,
    output logic                nlc,
    output logic                cfen,
    output logic                crcfwd,
    output logic                paufwd,
    output logic                paden,
    output logic                fce,
    output logic                bc_rej,
    output logic                prom,
    output logic [MAX_FL_W-1:0] max_fl,
    output logic                rx_stopped,
    output logic                soft_rst
);

    localparam logic [MAX_FL_W-1:0] MAX_FL_RST_W = MAX_FL_W'(MAX_FL_RST);
    localparam logic [MAX_FL_W-1:0] MIN_FL_W     = MAX_FL_W'(MIN_FL);

    cfg_state_e state_q, state_d;
    logic       rx_stopped_q, rx_stopped_d;
    logic       soft_rst_q, soft_rst_d;

    logic srst, any_wen, commit, rcr_we, ecr_we;
    logic ether_en_next;

    logic [31:0]         rcr_shadow, rcr_active;
    logic                ether_en_shadow, ether_en_active;
    logic                mii_sel_shadow, mii_sel_active;
    logic [MAX_FL_W-1:0] max_fl_shadow, max_fl_active;
    logic [MAX_FL_W-1:0] max_fl_wr, max_fl_clamped;
    logic                unused_bits;

    // Strobe decode; a commit is only allowed on a quiet edge outside a frame
    always_comb begin
        srst          = ecr_wen & reg_wdata[ECR_RESET];
        any_wen       = rcr_wen | ecr_wen;
        rcr_we        = rcr_wen & ~srst;
        ecr_we        = ecr_wen & ~srst;
        commit        = (state_q == CFG_WAIT) & ~rx_frame_busy & ~any_wen & ~srst;
        max_fl_wr     = reg_wdata[ECR_MAX_FL_LSB +: MAX_FL_W];
        max_fl_clamped = (max_fl_wr < MIN_FL_W) ? MIN_FL_W : max_fl_wr;
        ether_en_next = srst   ? 1'b0 :
                        commit ? ether_en_shadow : ether_en_active;
    end

    // RCR fields: one register pair per implemented bit, others tied to 0
    for (genvar i = 0; i < 32; i++) begin : g_rcr
        if (RCR_MASK[i]) begin : g_fld
            enet_cfg_field #(.W(1), .RST(RCR_RST[i])) u_fld (
                .clk    (rx_clk),
                .rst_n  (rst_n),
                .clr    (srst),
                .wen    (rcr_we),
                .wdata  (reg_wdata[i]),
                .commit (commit),
                .shadow (rcr_shadow[i]),
                .active (rcr_active[i])
            );
        end else begin : g_tie
            assign rcr_shadow[i] = 1'b0;
            assign rcr_active[i] = 1'b0;
        end
    end

    enet_cfg_field #(.W(1), .RST(1'b0)) u_ether_en (
        .clk    (rx_clk),
        .rst_n  (rst_n),
        .clr    (srst),
        .wen    (ecr_we),
        .wdata  (reg_wdata[ECR_ETHER_EN]),
        .commit (commit),
        .shadow (ether_en_shadow),
        .active (ether_en_active)
    );

    enet_cfg_field #(.W(1), .RST(1'b0)) u_mii_sel (
        .clk    (rx_clk),
        .rst_n  (rst_n),
        .clr    (srst),
        .wen    (ecr_we),
        .wdata  (reg_wdata[ECR_MII_SEL]),
        .commit (commit),
        .shadow (mii_sel_shadow),
        .active (mii_sel_active)
    );

    enet_cfg_field #(.W(MAX_FL_W), .RST(MAX_FL_RST_W)) u_max_fl (
        .clk    (rx_clk),
        .rst_n  (rst_n),
        .clr    (srst),
        .wen    (ecr_we),
        .wdata  (max_fl_clamped),
        .commit (commit),
        .shadow (max_fl_shadow),
        .active (max_fl_active)
    );

    // Commit FSM next state and pulse generation
    always_comb begin
        state_d = state_q;
        if (srst)         state_d = CFG_SYNCED;
        else if (any_wen) state_d = CFG_WAIT;
        else if (commit)  state_d = CFG_SYNCED;
        rx_stopped_d = ether_en_active & ~ether_en_next;
        soft_rst_d   = srst;
    end

    // Commit FSM state and registered pulses
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CFG_SYNCED;
            rx_stopped_q <= 1'b0;
            soft_rst_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_stopped_q <= rx_stopped_d;
            soft_rst_q   <= soft_rst_d;
        end
    end

    // Readback assembly from shadow state
    always_comb begin
        ecr_rdata = '0;
        ecr_rdata[ECR_MAX_FL_LSB +: MAX_FL_W] = max_fl_shadow;
        ecr_rdata[ECR_MII_SEL]                = mii_sel_shadow;
        ecr_rdata[ECR_ETHER_EN]               = ether_en_shadow;
    end

    assign rcr_rdata   = rcr_shadow;
    assign cfg_pending = (state_q == CFG_WAIT);
    assign ether_en    = ether_en_active;
    assign mii_select  = mii_sel_active;
    assign max_fl      = max_fl_active;
    assign drt         = rcr_active[RCR_DRT];
    assign nlc         = rcr_active[RCR_NLC];
    assign cfen        = rcr_active[RCR_CFEN];
    assign crcfwd      = rcr_active[RCR_CRCFWD];
    assign paufwd      = rcr_active[RCR_PAUFWD];
    assign paden       = rcr_active[RCR_PADEN];
    assign fce         = rcr_active[RCR_FCE];
    assign bc_rej      = rcr_active[RCR_BC_REJ];
    assign prom        = rcr_active[RCR_PROM];
    assign rx_stopped  = rx_stopped_q;
    assign soft_rst    = soft_rst_q;

    assign unused_bits = ^{reg_wdata, rcr_active};

endmodule
